// File: rtl/e1_stage_pkg.sv
// Shared core definitions for the E1 stage: exception codes, stall counter
// state encoding and the exception-merge helper.
package e1_stage_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_IBE  = 5'd6;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [7:0] STALL_MAX = 8'd255;

  typedef enum logic [0:0] {
    STALL_RUN     = 1'b0,
    STALL_STALLED = 1'b1
  } stall_state_t;

  // The earlier pipeline stage reports first, so its code wins.
  function automatic logic [4:0] merge_exc_code(input logic       d1_exc,
                                                input logic [4:0] d1_code,
                                                input logic [4:0] d2_code);
    return d1_exc ? d1_code : d2_code;
  endfunction

endpackage

// File: rtl/e1_stall_counter.sv
// Counts consecutive held cycles of the E1 stage, saturating at STALL_MAX;
// any advancing cycle returns it to RUN with a zero count.
module e1_stall_counter
  import e1_stage_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] count
);

  stall_state_t state;
  stall_state_t state_next;
  logic [7:0]   count_next;

  // State and count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STALL_RUN;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state and next-count logic
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      STALL_RUN: begin
        if (en) begin
          state_next = STALL_RUN;
          count_next = 8'd0;
        end else begin
          state_next = STALL_STALLED;
          count_next = 8'd1;
        end
      end
      STALL_STALLED: begin
        if (en) begin
          state_next = STALL_RUN;
          count_next = 8'd0;
        end else begin
          state_next = STALL_STALLED;
          count_next = (count == STALL_MAX) ? count : count + 8'd1;
        end
      end
      default: begin
        state_next = STALL_RUN;
        count_next = 8'd0;
      end
    endcase
  end

endmodule

// File: rtl/e1_stage.sv
// E1 pipeline register: captures the issued D2 instruction, merges exceptions,
// supports stall with late operand forwarding and flush-to-bubble.
module e1_stage
  import e1_stage_pkg::*;
#(
  parameter bit FWD_HOLD = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        D2_Issued,
  input  logic [31:0] D2_Instruction,
  input  logic [31:0] D2_RestartPC,
  input  logic        D2_IsBDS,
  input  logic [31:0] D2_Operand1,
  input  logic [31:0] D2_Operand2,
  input  logic [31:0] E1_Operand1_Fwd,
  input  logic [31:0] E1_Operand2_Fwd,
  input  logic        D2_D1Exception,
  input  logic [4:0]  D2_D1ExcCode,
  input  logic        D2_Exception,
  input  logic [4:0]  D2_ExcCode,
  input  logic [31:0] D2_BadVAddr,
  input  logic        E1_Stall,
  input  logic        E1_Flush,
  output logic        E1_D2Issued,
  output logic [31:0] E1_Instruction,
  output logic [31:0] E1_RestartPC,
  output logic [31:0] E1_BadVAddr,
  output logic        E1_IsBDS,
  output logic [31:0] E1_Operand1,
  output logic [31:0] E1_Operand2,
  output logic        E1_Exception,
  output logic [4:0]  E1_ExcCode,
  output logic [7:0]  E1_StallCount
);

  logic en;
  logic load;

  assign en   = ~E1_Stall | E1_Flush;
  assign load = en & ~E1_Flush;

  // Control state: reset to a clean bubble; a flush only needs to kill validity.
  always_ff @(posedge clock) begin
    if (reset) begin
      E1_D2Issued  <= 1'b0;
      E1_Exception <= 1'b0;
      E1_ExcCode   <= EXC_INT;
      E1_IsBDS     <= 1'b0;
      E1_RestartPC <= 32'd0;
    end else if (en) begin
      if (E1_Flush) begin
        E1_D2Issued  <= 1'b0;
        E1_Exception <= 1'b0;
      end else begin
        E1_D2Issued  <= D2_Issued;
        E1_Exception <= D2_Issued & (D2_D1Exception | D2_Exception);
        E1_ExcCode   <= merge_exc_code(D2_D1Exception, D2_D1ExcCode, D2_ExcCode);
        E1_IsBDS     <= D2_IsBDS;
      end
      // Delay-slot instructions keep the branch's PC so a restart re-runs the branch.
      if (D2_Issued && !D2_IsBDS) begin
        E1_RestartPC <= D2_RestartPC;
      end
    end
  end

  // Datapath registers carry no reset; operands may be refreshed while held.
  always_ff @(posedge clock) begin
    if (load) begin
      E1_Instruction <= D2_Instruction;
      E1_Operand1    <= D2_Operand1;
      E1_Operand2    <= D2_Operand2;
      if (D2_D1Exception) begin
        E1_BadVAddr <= D2_BadVAddr;
      end
    end else if (!en && FWD_HOLD) begin
      E1_Operand1 <= E1_Operand1_Fwd;
      E1_Operand2 <= E1_Operand2_Fwd;
    end
  end

  e1_stall_counter u_stall_counter (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .count (E1_StallCount)
  );

endmodule

// File: tb/tb_e1_stage.sv
// Randomized self-checking bench for e1_stage against a cycle-level behavioural
// model, with directed scenarios for load, stall/forward, flush, priority, BDS, saturation.
module tb_e1_stage;
  import e1_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        D2_Issued;
  logic [31:0] D2_Instruction, D2_RestartPC;
  logic        D2_IsBDS;
  logic [31:0] D2_Operand1, D2_Operand2, E1_Operand1_Fwd, E1_Operand2_Fwd;
  logic        D2_D1Exception, D2_Exception;
  logic [4:0]  D2_D1ExcCode, D2_ExcCode;
  logic [31:0] D2_BadVAddr;
  logic        E1_Stall, E1_Flush;
  logic        E1_D2Issued, E1_IsBDS, E1_Exception;
  logic [31:0] E1_Instruction, E1_RestartPC, E1_BadVAddr, E1_Operand1, E1_Operand2;
  logic [4:0]  E1_ExcCode;
  logic [7:0]  E1_StallCount;

  int checks = 0;
  int errors = 0;

  // Reference state and which fields currently hold a defined value
  logic        m_issued, m_exc, m_bds;
  logic [4:0]  m_code;
  logic [31:0] m_instr, m_rpc, m_op1, m_op2, m_bva;
  int          m_cnt;
  bit          k_instr, k_rpc, k_bds, k_ops, k_code, k_bva;

  always #5 clock = ~clock;

  e1_stage #(.FWD_HOLD(1'b1)) dut (
    .clock(clock), .reset(reset),
    .D2_Issued(D2_Issued), .D2_Instruction(D2_Instruction),
    .D2_RestartPC(D2_RestartPC), .D2_IsBDS(D2_IsBDS),
    .D2_Operand1(D2_Operand1), .D2_Operand2(D2_Operand2),
    .E1_Operand1_Fwd(E1_Operand1_Fwd), .E1_Operand2_Fwd(E1_Operand2_Fwd),
    .D2_D1Exception(D2_D1Exception), .D2_D1ExcCode(D2_D1ExcCode),
    .D2_Exception(D2_Exception), .D2_ExcCode(D2_ExcCode),
    .D2_BadVAddr(D2_BadVAddr), .E1_Stall(E1_Stall), .E1_Flush(E1_Flush),
    .E1_D2Issued(E1_D2Issued), .E1_Instruction(E1_Instruction),
    .E1_RestartPC(E1_RestartPC), .E1_BadVAddr(E1_BadVAddr),
    .E1_IsBDS(E1_IsBDS), .E1_Operand1(E1_Operand1), .E1_Operand2(E1_Operand2),
    .E1_Exception(E1_Exception), .E1_ExcCode(E1_ExcCode),
    .E1_StallCount(E1_StallCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    reset = 1'b0; D2_Issued = 1'b0; D2_Instruction = 32'd0; D2_RestartPC = 32'd0;
    D2_IsBDS = 1'b0; D2_Operand1 = 32'd0; D2_Operand2 = 32'd0;
    E1_Operand1_Fwd = 32'd0; E1_Operand2_Fwd = 32'd0;
    D2_D1Exception = 1'b0; D2_D1ExcCode = 5'd0; D2_Exception = 1'b0; D2_ExcCode = 5'd0;
    D2_BadVAddr = 32'd0; E1_Stall = 1'b0; E1_Flush = 1'b0;
  endtask

  task automatic set_random();
    reset = ($urandom_range(0, 99) == 0);
    D2_Issued = ($urandom_range(0, 3) != 0);
    D2_Instruction = $urandom; D2_RestartPC = $urandom;
    D2_IsBDS = ($urandom_range(0, 3) == 0);
    D2_Operand1 = $urandom; D2_Operand2 = $urandom;
    E1_Operand1_Fwd = $urandom; E1_Operand2_Fwd = $urandom;
    D2_D1Exception = ($urandom_range(0, 4) == 0); D2_D1ExcCode = 5'($urandom_range(0, 31));
    D2_Exception = ($urandom_range(0, 4) == 0); D2_ExcCode = 5'($urandom_range(0, 31));
    D2_BadVAddr = $urandom;
    E1_Stall = ($urandom_range(0, 9) < 4);
    E1_Flush = ($urandom_range(0, 9) == 0);
  endtask

  // Advance the model one clock from the inputs visible at the edge.
  task automatic model_update();
    if (reset) begin
      m_issued = 1'b0; m_exc = 1'b0; m_code = 5'd0; m_bds = 1'b0; m_rpc = 32'd0; m_cnt = 0;
      k_code = 1; k_bds = 1; k_rpc = 1; k_instr = 0; k_ops = 0; k_bva = 0;
    end else if (E1_Flush) begin
      m_issued = 1'b0; m_exc = 1'b0; m_cnt = 0;
      k_instr = 0; k_rpc = 0; k_bds = 0; k_ops = 0; k_code = 0; k_bva = 0;
    end else if (E1_Stall) begin
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_op1 = E1_Operand1_Fwd; m_op2 = E1_Operand2_Fwd; k_ops = 1;
    end else begin
      m_cnt = 0;
      m_issued = D2_Issued;
      m_instr = D2_Instruction; k_instr = 1;
      m_op1 = D2_Operand1; m_op2 = D2_Operand2; k_ops = 1;
      m_bds = D2_IsBDS; k_bds = 1;
      m_exc = D2_Issued && (D2_D1Exception || D2_Exception);
      m_code = D2_D1Exception ? D2_D1ExcCode : D2_ExcCode; k_code = 1;
      if (D2_Issued && !D2_IsBDS) begin m_rpc = D2_RestartPC; k_rpc = 1; end
      if (D2_D1Exception) begin m_bva = D2_BadVAddr; k_bva = 1; end
    end
  endtask

  task automatic compare_all();
    check("issued", 32'(E1_D2Issued), 32'(m_issued));
    check("exception", 32'(E1_Exception), 32'(m_exc));
    check("stall_count", 32'(E1_StallCount), 32'(m_cnt));
    if (k_code)  check("exc_code", 32'(E1_ExcCode), 32'(m_code));
    if (k_bds)   check("is_bds", 32'(E1_IsBDS), 32'(m_bds));
    if (k_rpc)   check("restart_pc", E1_RestartPC, m_rpc);
    if (k_instr) check("instruction", E1_Instruction, m_instr);
    if (k_bva)   check("bad_vaddr", E1_BadVAddr, m_bva);
    if (k_ops) begin
      check("operand1", E1_Operand1, m_op1);
      check("operand2", E1_Operand2, m_op2);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_issued"}, 32'(E1_D2Issued), 32'd0);
    check({tag, "_exc"}, 32'(E1_Exception), 32'd0);
    check({tag, "_code"}, 32'(E1_ExcCode), 32'd0);
    check({tag, "_cnt"}, 32'(E1_StallCount), 32'd0);
    check({tag, "_bds"}, 32'(E1_IsBDS), 32'd0);
    check({tag, "_rpc"}, E1_RestartPC, 32'd0);
  endtask

  initial begin
    m_cnt = 0; k_instr = 0; k_rpc = 0; k_bds = 0; k_ops = 0; k_code = 0; k_bva = 0;
    m_issued = 1'b0; m_exc = 1'b0;
    set_idle();
    reset = 1'b1;
    @(posedge clock); model_update();
    step();
    check_reset_values("reset");

    // Plain load
    set_idle();
    D2_Issued = 1'b1; D2_Instruction = 32'h2402000A; D2_RestartPC = 32'h80000100;
    D2_Operand1 = 32'h11111111; D2_Operand2 = 32'h22222222;
    step();
    check("load_instr", E1_Instruction, 32'h2402000A);
    check("load_rpc", E1_RestartPC, 32'h80000100);
    check("load_issued", 32'(E1_D2Issued), 32'd1);

    // Stall three cycles with a late forward
    D2_Instruction = 32'h00000000; E1_Stall = 1'b1; E1_Operand1_Fwd = 32'hDEADBEEF;
    repeat (3) step();
    check("fwd_op1", E1_Operand1, 32'hDEADBEEF);
    check("fwd_instr_held", E1_Instruction, 32'h2402000A);
    check("fwd_cnt", 32'(E1_StallCount), 32'd3);

    // Flush overrides stall and suppresses the exception
    E1_Flush = 1'b1; D2_Exception = 1'b1; D2_ExcCode = EXC_OV;
    step();
    check("flush_issued", 32'(E1_D2Issued), 32'd0);
    check("flush_exc", 32'(E1_Exception), 32'd0);
    check("flush_cnt", 32'(E1_StallCount), 32'd0);

    // Both stages raise; the earlier stage's code and address win
    set_idle();
    D2_Issued = 1'b1; D2_D1Exception = 1'b1; D2_D1ExcCode = EXC_ADEL;
    D2_Exception = 1'b1; D2_ExcCode = EXC_RI; D2_BadVAddr = 32'hBFC00ABC;
    step();
    check("prio_code", 32'(E1_ExcCode), 32'd4);
    check("prio_bva", E1_BadVAddr, 32'hBFC00ABC);
    check("prio_exc", 32'(E1_Exception), 32'd1);

    // Branch followed by its delay slot
    set_idle();
    D2_Issued = 1'b1; D2_RestartPC = 32'h80000200; D2_Instruction = 32'h10000004;
    step();
    D2_RestartPC = 32'h80000204; D2_IsBDS = 1'b1; D2_Instruction = 32'h00000000;
    step();
    check("bds_rpc", E1_RestartPC, 32'h80000200);
    check("bds_flag", 32'(E1_IsBDS), 32'd1);

    // Long stall saturates, then reset mid-stall clears everything
    set_idle();
    E1_Stall = 1'b1;
    repeat (300) step();
    check("sat_cnt", 32'(E1_StallCount), 32'd255);
    reset = 1'b1;
    step();
    check_reset_values("stall_reset");
    reset = 1'b0;

    repeat (3000) begin
      set_random();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
